pc_flow_controller: RTL and testbench

- Sequences the program counter of the MUSA fetch stage and drives the 8-entry return-address stack's push/pop strobes.
- Resolves sequential, jump, call, return and interrupt-entry requests from the control unit, one per accepted cycle.
- Tracks stack depth so the stack never sees an illegal push or pop; an illegal request sends the core to a fault vector.

---
 rtl/pc_flow_controller.sv | 160 ++++++++++++++++
 tb/tb_pc_flow_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_flow_controller.sv
// Program-counter sequencer for the MUSA fetch stage: resolves sequential/jump/call/ret/irq
// requests and issues push/pop strobes to the 8-entry return-address stack.
module pc_flow_controller #(
   parameter int                  PC_WIDTH     = 13,
   parameter int                  DEPTH        = 8,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 13'h0000,
   parameter logic [PC_WIDTH-1:0] IRQ_VECTOR   = 13'h0004,
   parameter logic [PC_WIDTH-1:0] FAULT_VECTOR = 13'h0008
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                advance,
   input  logic                jump,
   input  logic                call,
   input  logic                ret,
   input  logic                irq,
   input  logic [PC_WIDTH-1:0] target,
   input  logic [PC_WIDTH-1:0] stackOut,
   input  logic                stackOverflow,
   output logic [PC_WIDTH-1:0] pc,
   output logic                readStack,
   output logic                writeStack,
   output logic [PC_WIDTH-1:0] pushData,
   output logic                irqAck,
   output logic                busy,
   output logic                fault,
   output logic [1:0]          faultCode
);

   localparam int DW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {RUN, POP_REQ, POP_LOAD, FAULT} state_t;

   state_t              state, state_n;
   logic [DW-1:0]       depth, depth_n, isr_depth, isr_depth_n, depth_dec;
   logic                in_isr, in_isr_n;
   logic [PC_WIDTH-1:0] pc_n, push_n;
   logic                rd_n, wr_n, ack_n, fault_n;
   logic [1:0]          code_n;
   logic                fault_req;
   logic [1:0]          fault_req_code;

   assign depth_dec = depth - DW'(1);

   // All architectural state and the strobes are registered together
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         pc         <= RESET_VECTOR;
         depth      <= '0;
         isr_depth  <= '0;
         in_isr     <= 1'b0;
         readStack  <= 1'b0;
         writeStack <= 1'b0;
         pushData   <= '0;
         irqAck     <= 1'b0;
         fault      <= 1'b0;
         faultCode  <= 2'b00;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         depth      <= depth_n;
         isr_depth  <= isr_depth_n;
         in_isr     <= in_isr_n;
         readStack  <= rd_n;
         writeStack <= wr_n;
         pushData   <= push_n;
         irqAck     <= ack_n;
         fault      <= fault_n;
         faultCode  <= code_n;
      end
   end

   always_comb begin
      state_n        = state;
      pc_n           = pc;
      depth_n        = depth;
      isr_depth_n    = isr_depth;
      in_isr_n       = in_isr;
      push_n         = pushData;
      rd_n           = 1'b0;
      wr_n           = 1'b0;
      ack_n          = 1'b0;
      fault_n        = fault;
      code_n         = faultCode;
      fault_req      = 1'b0;
      fault_req_code = 2'b00;
      case (state)
         RUN: if (advance) begin
            if (irq && !in_isr) begin
               if (depth == DW'(DEPTH)) begin
                  fault_req      = 1'b1;
                  fault_req_code = 2'b01;
               end else begin
                  // Push the interrupted pc itself so it is re-executed on return
                  wr_n        = 1'b1;
                  ack_n       = 1'b1;
                  push_n      = pc;
                  pc_n        = IRQ_VECTOR;
                  depth_n     = depth + DW'(1);
                  in_isr_n    = 1'b1;
                  isr_depth_n = depth;
               end
            end else if (ret) begin
               if (depth == '0) begin
                  fault_req      = 1'b1;
                  fault_req_code = 2'b10;
               end else begin
                  rd_n    = 1'b1;
                  state_n = POP_REQ;
               end
            end else if (call) begin
               if (depth == DW'(DEPTH)) begin
                  fault_req      = 1'b1;
                  fault_req_code = 2'b01;
               end else begin
                  wr_n    = 1'b1;
                  push_n  = pc + PC_WIDTH'(1);
                  pc_n    = target;
                  depth_n = depth + DW'(1);
               end
            end else if (jump) begin
               pc_n = target;
            end else begin
               pc_n = pc + PC_WIDTH'(1);
            end
         end
         POP_REQ: state_n = POP_LOAD;
         POP_LOAD: begin
            pc_n    = stackOut;
            depth_n = depth_dec;
            if (in_isr && depth_dec == isr_depth) in_isr_n = 1'b0;
            state_n = RUN;
         end
         default: ;
      endcase
      // A stack-reported error overrides whatever the state was doing
      if (stackOverflow && state != FAULT) begin
         fault_req      = 1'b1;
         fault_req_code = 2'b11;
      end
      if (fault_req) begin
         state_n = FAULT;
         pc_n    = FAULT_VECTOR;
         depth_n = depth;
         in_isr_n    = in_isr;
         isr_depth_n = isr_depth;
         fault_n = 1'b1;
         code_n  = fault_req_code;
         rd_n    = 1'b0;
         wr_n    = 1'b0;
         ack_n   = 1'b0;
      end
   end

   always_comb begin
      busy = (state != RUN);
   end

endmodule

// File: tb/tb_pc_flow_controller.sv
// Directed bench for pc_flow_controller with a small synchronous return-stack model.
module tb_pc_flow_controller;

   logic        clk = 1'b0;
   logic        reset, advance, jump, call, ret, irq, stackOverflow;
   logic [12:0] target, stackOut, pc, pushData;
   logic        readStack, writeStack, irqAck, busy, fault;
   logic [1:0]  faultCode;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pc_flow_controller dut (
      .clk(clk), .reset(reset), .advance(advance), .jump(jump), .call(call), .ret(ret),
      .irq(irq), .target(target), .stackOut(stackOut), .stackOverflow(stackOverflow),
      .pc(pc), .readStack(readStack), .writeStack(writeStack), .pushData(pushData),
      .irqAck(irqAck), .busy(busy), .fault(fault), .faultCode(faultCode)
   );

   // Return stack: synchronous reset, push/pop sampled at the rising edge
   logic [12:0] smem [0:15];
   int sp = 0;
   always @(posedge clk) begin
      if (reset) begin
         sp <= 0;
         stackOut <= '0;
      end else begin
         if (writeStack) begin
            smem[sp] <= pushData;
            sp <= sp + 1;
         end else if (readStack && sp > 0) begin
            stackOut <= smem[sp-1];
            sp <= sp - 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      advance = 0; jump = 0; call = 0; ret = 0; irq = 0; stackOverflow = 0; target = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step();
      reset = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      #1;
      vectors++;
      if ({pc, readStack, writeStack, irqAck, busy, fault, faultCode} !== 20'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: pc=%h rd=%b wr=%b ack=%b busy=%b fault=%b code=%b expected all 0",
                  pc, readStack, writeStack, irqAck, busy, fault, faultCode);
      end
      step();
      reset = 0;
   endtask

   task automatic test_sequential();
      do_reset();
      advance = 1;
      for (int i = 1; i <= 3; i++) begin
         step();
         vectors++;
         if (pc !== 13'(i)) begin
            miscompares++;
            $display("FAIL seq_pc%0d: got %h expected %h", i, pc, 13'(i));
         end
      end
      jump = 1; target = 13'h1FFF;
      step();
      vectors++;
      if (pc !== 13'h1FFF) begin miscompares++; $display("FAIL jump_pc: got %h expected 1fff", pc); end
      jump = 0;
      step();
      vectors++;
      if (pc !== 13'h0000) begin miscompares++; $display("FAIL seq_wrap: got %h expected 0000", pc); end
      advance = 0;
      step();
      vectors++;
      if (pc !== 13'h0000 || writeStack !== 1'b0) begin
         miscompares++; $display("FAIL hold_pc: got pc=%h wr=%b expected 0000/0", pc, writeStack);
      end
   endtask

   task automatic test_call_ret();
      do_reset();
      advance = 1; jump = 1; target = 13'h0010;
      step();
      jump = 0; call = 1; target = 13'h0100;
      step();
      vectors++;
      if (writeStack !== 1'b1 || pushData !== 13'h0011 || pc !== 13'h0100 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL call: wr=%b push=%h pc=%h busy=%b expected 1/0011/0100/0", writeStack, pushData, pc, busy);
      end
      call = 0; ret = 1;
      step();
      ret = 0;
      vectors++;
      if (readStack !== 1'b1 || busy !== 1'b1 || writeStack !== 1'b0 || pc !== 13'h0100) begin
         miscompares++;
         $display("FAIL ret_pop_req: rd=%b busy=%b wr=%b pc=%h expected 1/1/0/0100", readStack, busy, writeStack, pc);
      end
      step();
      vectors++;
      if (readStack !== 1'b0 || busy !== 1'b1) begin
         miscompares++; $display("FAIL ret_pop_load: rd=%b busy=%b expected 0/1", readStack, busy);
      end
      step();
      vectors++;
      if (pc !== 13'h0011 || busy !== 1'b0) begin
         miscompares++; $display("FAIL ret_pc: pc=%h busy=%b expected 0011/0", pc, busy);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      advance = 1; call = 1; target = 13'h0040;
      for (int i = 0; i < 8; i++) begin
         step();
         vectors++;
         if (writeStack !== 1'b1 || fault !== 1'b0 || pushData !== (i == 0 ? 13'h0001 : 13'h0041)) begin
            miscompares++;
            $display("FAIL call_burst%0d: wr=%b fault=%b push=%h", i, writeStack, fault, pushData);
         end
      end
      step();
      vectors++;
      if (fault !== 1'b1 || faultCode !== 2'b01 || pc !== 13'h0008 || writeStack !== 1'b0) begin
         miscompares++;
         $display("FAIL call_overflow: fault=%b code=%b pc=%h wr=%b expected 1/01/0008/0", fault, faultCode, pc, writeStack);
      end
      call = 0; jump = 1; target = 13'h0055;
      step();
      step();
      vectors++;
      if (pc !== 13'h0008 || busy !== 1'b1 || fault !== 1'b1 || faultCode !== 2'b01) begin
         miscompares++;
         $display("FAIL fault_sticky: pc=%h busy=%b fault=%b code=%b expected 0008/1/1/01", pc, busy, fault, faultCode);
      end
   endtask

   task automatic test_underflow_and_async_reset();
      bit saw_rd = 0;
      do_reset();
      advance = 1; ret = 1;
      step();
      if (readStack) saw_rd = 1;
      ret = 0;
      step();
      if (readStack) saw_rd = 1;
      vectors++;
      if (fault !== 1'b1 || faultCode !== 2'b10 || pc !== 13'h0008 || saw_rd) begin
         miscompares++;
         $display("FAIL ret_underflow: fault=%b code=%b pc=%h rd_seen=%b expected 1/10/0008/0", fault, faultCode, pc, saw_rd);
      end
      do_reset();
      advance = 1; call = 1; target = 13'h0030;
      step();
      call = 0; ret = 1;
      step();
      ret = 0;
      vectors++;
      if (readStack !== 1'b1 || busy !== 1'b1) begin
         miscompares++; $display("FAIL pop_req_setup: rd=%b busy=%b expected 1/1", readStack, busy);
      end
      #2 reset = 1;
      #1;
      vectors++;
      if ({pc, readStack, writeStack, irqAck, busy, fault, faultCode} !== 20'h0) begin
         miscompares++;
         $display("FAIL async_reset: pc=%h rd=%b wr=%b ack=%b busy=%b fault=%b expected all 0",
                  pc, readStack, writeStack, irqAck, busy, fault);
      end
      idle_inputs();
      step();
      reset = 0;
   endtask

   task automatic test_irq();
      do_reset();
      advance = 1; jump = 1; target = 13'h0020;
      step();
      jump = 0; irq = 1; call = 1; target = 13'h0100;
      step();
      vectors++;
      if (writeStack !== 1'b1 || pushData !== 13'h0020 || pc !== 13'h0004 || irqAck !== 1'b1) begin
         miscompares++;
         $display("FAIL irq_entry: wr=%b push=%h pc=%h ack=%b expected 1/0020/0004/1", writeStack, pushData, pc, irqAck);
      end
      call = 0;
      step();
      vectors++;
      if (pc !== 13'h0005 || irqAck !== 1'b0 || writeStack !== 1'b0) begin
         miscompares++; $display("FAIL irq_no_reentry: pc=%h ack=%b wr=%b expected 0005/0/0", pc, irqAck, writeStack);
      end
      ret = 1;
      step();
      ret = 0;
      step();
      step();
      vectors++;
      if (pc !== 13'h0020 || busy !== 1'b0 || irqAck !== 1'b0) begin
         miscompares++; $display("FAIL irq_return: pc=%h busy=%b ack=%b expected 0020/0/0", pc, busy, irqAck);
      end
      step();
      vectors++;
      if (irqAck !== 1'b1 || pc !== 13'h0004 || pushData !== 13'h0020 || writeStack !== 1'b1) begin
         miscompares++;
         $display("FAIL irq_retake: ack=%b pc=%h push=%h wr=%b expected 1/0004/0020/1", irqAck, pc, pushData, writeStack);
      end
      irq = 0;
   endtask

   task automatic test_stack_error();
      int bad = 0;
      do_reset();
      advance = 0; stackOverflow = 1;
      step();
      stackOverflow = 0;
      vectors++;
      if (fault !== 1'b1 || faultCode !== 2'b11 || pc !== 13'h0008) begin
         miscompares++; $display("FAIL stack_error: fault=%b code=%b pc=%h expected 1/11/0008", fault, faultCode, pc);
      end
      advance = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (fault !== 1'b1 || faultCode !== 2'b11 || pc !== 13'h0008) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL stack_error_hold: %0d of 20 cycles lost fault/code/pc, expected 0", bad);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_sequential();
      test_call_ret();
      test_overflow();
      test_underflow_and_async_reset();
      test_irq();
      test_stack_error();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
